// File: rtl/logic_unit_seq.sv
// rtl/logic_unit_seq.sv - multi-cycle sliced 32-bit AND/OR/XOR/NOR unit with start/done handshake
// Optional zero-result flag enabled by defining LOGIC_UNIT_ZFLAG_EN.
module logic_unit_seq #(
   parameter int SLICE_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] out,
   output logic        zero
);

   localparam int NUM_SLICES = 32 / SLICE_W;
   localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_op;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [31:0]        r_out;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;

   logic [SLICE_W-1:0] w_a_sl;
   logic [SLICE_W-1:0] w_b_sl;
   logic [SLICE_W-1:0] w_res_sl;
   logic [31:0]        w_next_out;
   logic               w_last;

   assign w_a_sl = r_a[r_cnt*SLICE_W +: SLICE_W];
   assign w_b_sl = r_b[r_cnt*SLICE_W +: SLICE_W];
   assign w_last = (r_cnt == LAST_CNT);

   // One shared slice-wide gate array; the counter selects which slice it sees.
   always_comb begin
      w_res_sl = '0;
      case (r_op)
         2'b00:   w_res_sl = w_a_sl & w_b_sl;
         2'b01:   w_res_sl = w_a_sl | w_b_sl;
         2'b10:   w_res_sl = w_a_sl ^ w_b_sl;
         default: w_res_sl = ~(w_a_sl | w_b_sl);
      endcase
   end

   always_comb begin
      w_next_out = r_out;
      w_next_out[r_cnt*SLICE_W +: SLICE_W] = w_res_sl;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_out   <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_RUN: begin
               r_out <= w_next_out;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept a new request, giving back-to-back issue.
               if (start) begin
                  r_state <= S_RUN;
                  r_cnt   <= '0;
                  r_op    <= op;
                  r_a     <= in1;
                  r_b     <= in2;
                  r_out   <= '0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef LOGIC_UNIT_ZFLAG_EN
   logic r_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zero <= 1'b0;
      end else if (r_state == S_RUN) begin
         if (w_last) begin
            r_zero <= (w_next_out == 32'h0);
         end
      end else if (start) begin
         r_zero <= 1'b0;
      end
   end

   assign zero = r_zero;
`else
   assign zero = 1'b0;
`endif

   assign ready = r_ready;
   assign busy  = r_busy;
   assign done  = r_done;
   assign out   = r_out;

endmodule
